// File: rtl/cache_req_arbiter.sv
// Round-robin front end for the shared L1/L2 cache read port: one lookup at a time,
// latency shaped by hit class, tagged response plus saturating hit/miss statistics.
module cache_req_arbiter #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 11,
    parameter int L2_LAT     = 4,
    parameter int MEM_LAT    = 12,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    output logic                  req1_ready,
    output logic                  resp_valid,
    output logic                  resp_id,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic [1:0]            resp_class,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic                  cache_read,
    input  logic [DATA_WIDTH-1:0] cache_read_data,
    input  logic                  cache_l1_hit,
    input  logic                  cache_l2_hit,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  l1_hits,
    output logic [CNT_WIDTH-1:0]  l2_hits,
    output logic [CNT_WIDTH-1:0]  misses
);

    localparam int MAX_LAT = (L2_LAT > MEM_LAT) ? L2_LAT : MEM_LAT;
    localparam int WAIT_W  = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT + 1);

    localparam logic [1:0]           CLS_L1   = 2'b00;
    localparam logic [1:0]           CLS_L2   = 2'b01;
    localparam logic [1:0]           CLS_MISS = 2'b10;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [WAIT_W-1:0]    L2_W     = WAIT_W'(L2_LAT);
    localparam logic [WAIT_W-1:0]    MEM_W    = WAIT_W'(MEM_LAT);

    typedef enum logic [2:0] {IDLE, ISSUE, SAMPLE, WAIT, RESP} state_e;

    state_e                state_q, state_d;
    logic                  prio_q, prio_d;
    logic                  id_q, id_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  resp_id_q, resp_id_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic [1:0]            resp_class_q, resp_class_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [CNT_WIDTH-1:0]  l1_q, l1_d, l2_q, l2_d, miss_q, miss_d;
    logic                  grant_id;
    logic                  can_accept;

    // With both requesters pending prio decides; otherwise the lone requester wins.
    assign grant_id   = (req0_valid && req1_valid) ? prio_q : req1_valid;
    assign can_accept = (state_q == IDLE) && !rst;
    assign req0_ready = can_accept && req0_valid && !grant_id;
    assign req1_ready = can_accept && req1_valid && grant_id;

    // NOTE: every variable gets its hold value first, so no path through the case infers a latch.
    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        id_d         = id_q;
        addr_d       = addr_q;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        resp_class_d = resp_class_q;
        wait_d       = wait_q;
        l1_d         = l1_q;
        l2_d         = l2_q;
        miss_d       = miss_q;
        unique case (state_q)
            IDLE: begin
                if (req0_ready || req1_ready) begin
                    id_d    = grant_id;
                    addr_d  = grant_id ? req1_addr : req0_addr;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = SAMPLE;
            SAMPLE: begin
                resp_data_d = cache_read_data;
                resp_id_d   = id_q;
                if (cache_l1_hit) begin
                    resp_class_d = CLS_L1;
                    state_d      = RESP;
                end else if (cache_l2_hit) begin
                    resp_class_d = CLS_L2;
                    wait_d       = L2_W;
                    state_d      = (L2_LAT == 0) ? RESP : WAIT;
                end else begin
                    resp_class_d = CLS_MISS;
                    wait_d       = MEM_W;
                    state_d      = (MEM_LAT == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                // Leaving on a count of 1 makes WAIT last exactly the loaded number of cycles.
                if (wait_q == WAIT_W'(1)) state_d = RESP;
                else                      wait_d  = wait_q - WAIT_W'(1);
            end
            RESP: begin
                unique case (resp_class_q)
                    CLS_L1:  if (l1_q != CNT_MAX) l1_d = l1_q + CNT_WIDTH'(1);
                    CLS_L2:  if (l2_q != CNT_MAX) l2_d = l2_q + CNT_WIDTH'(1);
                    default: if (miss_q != CNT_MAX) miss_d = miss_q + CNT_WIDTH'(1);
                endcase
                prio_d  = ~id_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            prio_q       <= 1'b0;
            id_q         <= 1'b0;
            addr_q       <= '0;
            resp_id_q    <= 1'b0;
            resp_data_q  <= '0;
            resp_class_q <= CLS_L1;
            wait_q       <= '0;
            l1_q         <= '0;
            l2_q         <= '0;
            miss_q       <= '0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            id_q         <= id_d;
            addr_q       <= addr_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            resp_class_q <= resp_class_d;
            wait_q       <= wait_d;
            l1_q         <= l1_d;
            l2_q         <= l2_d;
            miss_q       <= miss_d;
        end
    end

    assign cache_read = (state_q == ISSUE);
    assign resp_valid = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign cache_addr = addr_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign resp_class = resp_class_q;
    assign l1_hits    = l1_q;
    assign l2_hits    = l2_q;
    assign misses     = miss_q;

endmodule

// File: doc/cache_req_arbiter.md
# cache_req_arbiter

Front-end controller for the 2-way set-associative L1/L2 cache system. It shares the single cache read port between two requesters using round-robin arbitration. It sequences one lookup at a time (issue, sample hit/miss result, model L2 or memory latency) and returns a tagged response to the originating requester. It also keeps saturating L1-hit, L2-hit and miss counters for the simulator's statistics.

## Interface
- ADDR_WIDTH, 11, request/cache address width
- DATA_WIDTH, 11, read data width
- L2_LAT, 4, extra wait cycles applied to an L2 hit (0 allowed)
- MEM_LAT, 12, extra wait cycles applied to a full miss (0 allowed)
- CNT_WIDTH, 16, width of each statistics counter
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req0_valid / req1_valid  in  1  requester N has a read pending
- req0_addr / req1_addr  in  ADDR_WIDTH  requester N address, sampled on acceptance
- req0_ready / req1_ready  out  1  combinational; high only in IDLE for the granted requester
- resp_valid  out  1  one-cycle response strobe (no backpressure)
- resp_id  out  1  requester that owns the response
- resp_data  out  DATA_WIDTH  read data
- resp_class  out  2  00 = L1 hit, 01 = L2 hit, 10 = miss (11 never driven)
- cache_addr  out  ADDR_WIDTH  address to cache, held stable from ISSUE through RESP
- cache_read  out  1  one-cycle lookup strobe to cache
- cache_read_data  in  DATA_WIDTH  cache result, registered by the cache on the ISSUE edge
- cache_l1_hit, cache_l2_hit  in  1  cache hit flags, same timing as cache_read_data
- busy  out  1  state != IDLE
- l1_hits, l2_hits, misses  out  CNT_WIDTH  saturating event counters

## Operation
- FSM states: IDLE, ISSUE, SAMPLE, WAIT, RESP.
- IDLE arbitration:
  - If exactly one reqN_valid is high, grant it.
  - If both are high, grant the requester named by priority pointer `prio` (reset value 0).
  - An accept is valid & ready at a clock edge. On accept, latch the address into cache_addr, latch the id, and go to ISSUE.
  - A requester may drop valid before acceptance without effect.
- ISSUE: cache_read = 1 for exactly this cycle, then go to SAMPLE.
- SAMPLE: capture cache_read_data into resp_data and classify the result. l1_hit takes precedence over l2_hit.
  - L1 hit: class 00, W = 0.
  - L2 hit: class 01, W = L2_LAT.
  - Neither: class 10, W = MEM_LAT.
  - If W == 0, go to RESP. Otherwise load the wait counter with W and go to WAIT.
- WAIT: decrement the counter each cycle. When the counter is 1, go to RESP, so WAIT lasts exactly W cycles.
- RESP:
  - resp_valid = 1 for one cycle, with resp_id, resp_data and resp_class stable.
  - Increment the counter matching the class, saturating at all-ones (no wrap).
  - Set prio to the requester that was not just served, then go to IDLE.
- Requests are never accepted outside IDLE; both readys stay low while busy.
- Outputs outside RESP:
  - resp_data, resp_class and resp_id hold their last values.
  - resp_valid = 0 and cache_read = 0.

## Timing
- Reset values: every output is 0, state = IDLE, prio = 0, all counters 0, cache_addr 0, resp_data 0.
- Reset mid-operation: aborts the current transaction with no resp_valid and clears all counters. The first cycle after release is IDLE.
- Cycle numbering: accept edge ends cycle 0.
  - cache_read is high in cycle 1 (ISSUE).
  - Classification happens in cycle 2 (SAMPLE).
  - resp_valid is high in cycle 3 + W.
- Latency is 3 cycles for an L1 hit, 3 + L2_LAT for an L2 hit and 3 + MEM_LAT for a miss.
- Earliest next accept is in the cycle after RESP, so back-to-back L1 hits complete every 4 cycles.
- Both valid at the same IDLE edge: the requester named by prio wins. The loser's ready stays low and it waits.
- A single active requester is served back-to-back regardless of prio.
- Counter saturation: a counter at 2^CNT_WIDTH−1 stays there.

## Test plan
- Reset check: assert rst mid-cycle.
  - All outputs must go to 0 asynchronously.
  - After release with req0_valid=1, req0_ready=1 in IDLE.
- L1 hit: req0 accepts addr 0x155; bench cache drives l1_hit=1, data 0x0A5 in SAMPLE.
  - Required: cache_read in cycle 1, cache_addr=0x155, resp in cycle 3.
  - Required: resp_id=0, class 00, data 0x0A5, l1_hits=1.
- L2 hit, L2_LAT=4: req1 accepts addr 0x2A0; cache drives l2_hit=1, data 0x111.
  - Required: resp in cycle 7, resp_id=1, class 01, l2_hits=1.
- Miss, MEM_LAT=12: req0 accepts addr 0x7FF; cache drives no hit, data 0x3F3.
  - Required: resp in cycle 15, class 10, data 0x3F3, misses=1.
- Arbitration: both valid continuously from reset, all L1 hits.
  - Required service order 0,1,0,1.
  - Required: resp_valid every 4 cycles, never two grants while busy.
- Reset in WAIT, then saturation (CNT_WIDTH=2):
  - Reset during a miss wait: no resp_valid, counters 0.
  - Then 5 misses: misses=3, l1_hits=0, l2_hits=0.
